// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface imem_dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU: LSU priority,
// with fetch forced through after STARVE_MAX consecutive LSU wins.
//   state | meaning
//   IDLE  | no transaction outstanding; arbitration happens here (includes the rvalid cycle)
//   BUSY  | transaction outstanding for owner, lat_cnt counts down to the data capture
module imem_dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst_n,
    imem_dmem_arbiter_if.slave bus
);
    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, BUSY}     state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t                state, state_nxt;
    owner_t                owner, owner_nxt;
    logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
    logic [STARVE_W-1:0]   starve_cnt, starve_cnt_nxt;
    logic                  gnt_if, gnt_ls, done;
    logic                  if_req_v, ls_req_v;
    logic                  if_rvalid_q, ls_rvalid_q;
    logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;

    // Requests are masked during reset so every combinational output is low too.
    assign if_req_v = bus.if_req & rst_n;
    assign ls_req_v = bus.ls_req & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            lat_cnt     <= lat_cnt_nxt;
            starve_cnt  <= starve_cnt_nxt;
            if_rvalid_q <= done && (owner == OWN_IF);
            ls_rvalid_q <= done && (owner == OWN_LS);
            if (done && (owner == OWN_IF)) if_rdata_q <= bus.mem_rdata;
            if (done && (owner == OWN_LS)) ls_rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        gnt_if         = 1'b0;
        gnt_ls         = 1'b0;
        done           = 1'b0;

        case (state)
            IDLE: begin
                if (ls_req_v && !(if_req_v && (starve_cnt == STARVE_W'(STARVE_MAX))))
                    gnt_ls = 1'b1;
                else if (if_req_v)
                    gnt_if = 1'b1;
                if (gnt_ls || gnt_if) begin
                    state_nxt   = BUSY;
                    owner_nxt   = gnt_ls ? OWN_LS : OWN_IF;
                    lat_cnt_nxt = LAT_W'(MEM_LAT);
                end
            end
            BUSY: begin
                lat_cnt_nxt = lat_cnt - 1'b1;
                if (lat_cnt == LAT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!if_req_v || gnt_if)
            starve_cnt_nxt = '0;
        else if (gnt_ls && (starve_cnt != STARVE_W'(STARVE_MAX)))
            starve_cnt_nxt = starve_cnt + 1'b1;

        bus.mem_req   = gnt_if | gnt_ls;
        bus.mem_we    = gnt_ls & bus.ls_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_ls) begin
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
        end else if (gnt_if) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.ls_gnt    = gnt_ls;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.stall_if  = if_req_v & ~if_rvalid_q;
    assign bus.stall_mem = ls_req_v & ~ls_rvalid_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances,
// then randomized traffic checked against a transaction-level model of the arbiter.
module tb_imem_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 13;
    localparam int SM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    imem_dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

    imem_dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(1), .STARVE_MAX(SM))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    imem_dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(3), .STARVE_MAX(SM))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (32'(a) + 32'd1) * 32'h9e37_79b9;
    endfunction

    // Memory macros: data appears MEM_LAT cycles after the strobe, garbage otherwise.
    logic [DW-1:0] mem1 [512];
    bit   [511:0]  wr1;
    logic [DW-1:0] pipe1;
    always @(posedge clk) begin
        if (bus1.mem_req && bus1.mem_we) begin
            mem1[bus1.mem_addr[8:0]] <= bus1.mem_wdata;
            wr1[bus1.mem_addr[8:0]]  <= 1'b1;
        end
        if (bus1.mem_req && !bus1.mem_we)
            pipe1 <= wr1[bus1.mem_addr[8:0]] ? mem1[bus1.mem_addr[8:0]] : init_word(bus1.mem_addr);
        else
            pipe1 <= DW'($urandom);
    end
    assign bus1.mem_rdata = pipe1;

    logic [DW-1:0] pipe3 [3];
    always @(posedge clk) begin
        pipe3[0] <= (bus3.mem_req && !bus3.mem_we) ? init_word(bus3.mem_addr) : DW'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.mem_rdata = pipe3[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference memory contents, kept independently of the bench memory macro.
    logic [DW-1:0] ref1 [512];
    bit   [511:0]  rv1;
    function automatic logic [DW-1:0] ref_rd1(input logic [AW-1:0] a);
        return rv1[a[8:0]] ? ref1[a[8:0]] : init_word(a);
    endfunction
    task automatic ref_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref1[a[8:0]] = d;
        rv1[a[8:0]]  = 1'b1;
    endtask

    logic [DW-1:0] if_last, if_exp, ls_exp;
    bit            ls_exp_ld, exp_if_g, exp_ls_g, if_rv, ls_rv;
    int            free_at, if_done, ls_done, starve, if_st, ls_st;

    initial begin
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
        bus1.ls_addr = '0;  bus1.ls_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.ls_req = 1'b0; bus3.ls_we = 1'b0;
        bus3.ls_addr = '0;  bus3.ls_wdata = '0;
        if_last = '0;

        // Reset: all outputs low even with both requests present
        #2;
        bus1.if_req = 1'b1; bus1.ls_req = 1'b1; bus1.ls_addr = 13'h0aa; bus1.ls_wdata = 32'h1234_5678;
        #1;
        check_val("rst_if_gnt",    32'(bus1.if_gnt),    32'd0);
        check_val("rst_ls_gnt",    32'(bus1.ls_gnt),    32'd0);
        check_val("rst_mem_req",   32'(bus1.mem_req),   32'd0);
        check_val("rst_mem_addr",  32'(bus1.mem_addr),  32'd0);
        check_val("rst_mem_wdata", bus1.mem_wdata,      32'd0);
        check_val("rst_stall_if",  32'(bus1.stall_if),  32'd0);
        check_val("rst_stall_mem", 32'(bus1.stall_mem), 32'd0);
        check_val("rst_if_rvalid", 32'(bus1.if_rvalid), 32'd0);
        check_val("rst_ls_rvalid", 32'(bus1.ls_rvalid), 32'd0);
        check_val("rst_if_rdata",  bus1.if_rdata,       32'd0);
        check_val("rst_ls_rdata",  bus1.ls_rdata,       32'd0);
        bus1.if_req = 1'b0; bus1.ls_req = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single fetch, MEM_LAT=1
        tick();
        bus1.if_req = 1'b1; bus1.if_addr = 13'h010;
        #1;
        check_val("f1_if_gnt",   32'(bus1.if_gnt),   32'd1);
        check_val("f1_mem_req",  32'(bus1.mem_req),  32'd1);
        check_val("f1_mem_addr", 32'(bus1.mem_addr), 32'h010);
        check_val("f1_mem_we",   32'(bus1.mem_we),   32'd0);
        check_val("f1_stall_t0", 32'(bus1.stall_if), 32'd1);
        tick();
        check_val("f1_busy_gnt",   32'(bus1.if_gnt),    32'd0);
        check_val("f1_busy_req",   32'(bus1.mem_req),   32'd0);
        check_val("f1_stall_t1",   32'(bus1.stall_if),  32'd1);
        check_val("f1_rvalid_t1",  32'(bus1.if_rvalid), 32'd0);
        tick();
        check_val("f1_rvalid_t2",  32'(bus1.if_rvalid), 32'd1);
        check_val("f1_rdata",      bus1.if_rdata,       ref_rd1(13'h010));
        check_val("f1_stall_t2",   32'(bus1.stall_if),  32'd0);
        if_last = ref_rd1(13'h010);
        bus1.if_req = 1'b0;
        #1;
        check_val("f1_no_regnt",   32'(bus1.if_gnt),    32'd0);
        tick();
        check_val("f1_rvalid_t3",  32'(bus1.if_rvalid), 32'd0);

        // Simultaneous store and fetch: LSU first, then IF on the LSU rvalid cycle
        bus1.if_req = 1'b1; bus1.if_addr = 13'h020;
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 13'h100; bus1.ls_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("c_ls_gnt",    32'(bus1.ls_gnt),   32'd1);
        check_val("c_if_gnt",    32'(bus1.if_gnt),   32'd0);
        check_val("c_mem_we",    32'(bus1.mem_we),   32'd1);
        check_val("c_mem_addr",  32'(bus1.mem_addr), 32'h100);
        check_val("c_mem_wdata", bus1.mem_wdata,     32'hDEAD_BEEF);
        check_val("c_stall_if",  32'(bus1.stall_if), 32'd1);
        ref_wr1(13'h100, 32'hDEAD_BEEF);
        tick();
        check_val("c_busy_req",  32'(bus1.mem_req),   32'd0);
        check_val("c_stall_mem", 32'(bus1.stall_mem), 32'd1);
        tick();
        check_val("c_ls_rvalid", 32'(bus1.ls_rvalid), 32'd1);
        bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
        #1;
        check_val("c_if_gnt2",   32'(bus1.if_gnt),    32'd1);
        check_val("c_mem_addr2", 32'(bus1.mem_addr),  32'h020);
        check_val("c_stall_mem2",32'(bus1.stall_mem), 32'd0);
        tick();
        check_val("c_if_rv_t3",  32'(bus1.if_rvalid), 32'd0);
        tick();
        check_val("c_if_rv_t4",  32'(bus1.if_rvalid), 32'd1);
        check_val("c_if_rdata",  bus1.if_rdata,       ref_rd1(13'h020));
        if_last = ref_rd1(13'h020);
        bus1.if_req = 1'b0;
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 13'h100;
        #1;
        check_val("c_ld_gnt",    32'(bus1.ls_gnt),    32'd1);
        tick();
        tick();
        check_val("c_ld_rvalid", 32'(bus1.ls_rvalid), 32'd1);
        check_val("c_ld_rdata",  bus1.ls_rdata,       32'hDEAD_BEEF);
        bus1.ls_req = 1'b0;

        // Starvation: LSU hammering with IF held
        tick();
        bus1.if_req = 1'b1; bus1.if_addr = 13'h030;
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 13'h004;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick();
                tick();
            end
            check_val($sformatf("sv_if_gnt_%0d", k), 32'(bus1.if_gnt), 32'(k == 4));
            check_val($sformatf("sv_ls_gnt_%0d", k), 32'(bus1.ls_gnt), 32'(k != 4));
            if (k == 5) begin
                check_val("sv_if_rvalid", 32'(bus1.if_rvalid), 32'd1);
                check_val("sv_if_rdata",  bus1.if_rdata,       ref_rd1(13'h030));
                if_last = ref_rd1(13'h030);
            end
        end
        tick();
        tick();
        check_val("sv_ls_rvalid", 32'(bus1.ls_rvalid), 32'd1);
        bus1.ls_req = 1'b0; bus1.if_req = 1'b0;
        #1;
        check_val("sv_quiet", 32'(bus1.mem_req), 32'd0);
        tick();

        // Reset one cycle after a grant abandons the transaction
        bus1.if_req = 1'b1; bus1.if_addr = 13'h030;
        #1;
        check_val("ra_if_gnt", 32'(bus1.if_gnt), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_val("ra_if_gnt_rst", 32'(bus1.if_gnt),    32'd0);
        check_val("ra_mem_req",    32'(bus1.mem_req),   32'd0);
        check_val("ra_stall_if",   32'(bus1.stall_if),  32'd0);
        check_val("ra_if_rdata",   bus1.if_rdata,       32'd0);
        check_val("ra_ls_rdata",   bus1.ls_rdata,       32'd0);
        if_last = '0;
        bus1.if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("ra_no_rvalid", 32'(bus1.if_rvalid), 32'd0);
        end
        bus1.if_req = 1'b1; bus1.if_addr = 13'h050;
        #1;
        check_val("ra_fresh_gnt", 32'(bus1.if_gnt), 32'd1);
        tick();
        tick();
        check_val("ra_fresh_rv",  32'(bus1.if_rvalid), 32'd1);
        check_val("ra_fresh_rd",  bus1.if_rdata,       ref_rd1(13'h050));
        if_last = ref_rd1(13'h050);
        bus1.if_req = 1'b0;
        tick();

        // IF drops its request while BUSY
        bus1.if_req = 1'b1; bus1.if_addr = 13'h060;
        #1;
        check_val("dr_gnt", 32'(bus1.if_gnt), 32'd1);
        tick();
        bus1.if_req = 1'b0;
        #1;
        check_val("dr_stall", 32'(bus1.stall_if), 32'd0);
        tick();
        check_val("dr_rvalid", 32'(bus1.if_rvalid), 32'd1);
        check_val("dr_rdata",  bus1.if_rdata,       ref_rd1(13'h060));
        if_last = ref_rd1(13'h060);
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 13'h008;
        #1;
        check_val("dr_idle_gnt", 32'(bus1.ls_gnt), 32'd1);
        tick();
        check_val("dr_rvalid_once", 32'(bus1.if_rvalid), 32'd0);
        tick();
        check_val("dr_ls_rvalid", 32'(bus1.ls_rvalid), 32'd1);
        check_val("dr_ls_rdata",  bus1.ls_rdata,       ref_rd1(13'h008));
        bus1.ls_req = 1'b0;

        // MEM_LAT=3 instance: rvalid four cycles after grant, no strobe while BUSY
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 13'h040;
        #1;
        check_val("l3_gnt",     32'(bus3.ls_gnt),  32'd1);
        check_val("l3_mem_req", 32'(bus3.mem_req), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            bus3.if_req = 1'b1; bus3.if_addr = 13'h044;
            #1;
            check_val($sformatf("l3_busy_req_%0d", i), 32'(bus3.mem_req),   32'd0);
            check_val($sformatf("l3_busy_gnt_%0d", i), 32'(bus3.if_gnt),    32'd0);
            check_val($sformatf("l3_busy_rv_%0d", i),  32'(bus3.ls_rvalid), 32'd0);
        end
        tick();
        check_val("l3_rvalid", 32'(bus3.ls_rvalid), 32'd1);
        check_val("l3_rdata",  bus3.ls_rdata,       init_word(13'h040));
        bus3.ls_req = 1'b0;
        #1;
        check_val("l3_if_gnt", 32'(bus3.if_gnt), 32'd1);
        repeat (4) tick();
        check_val("l3_if_rvalid", 32'(bus3.if_rvalid), 32'd1);
        check_val("l3_if_rdata",  bus3.if_rdata,       init_word(13'h044));
        bus3.if_req = 1'b0;
        tick();

        // Randomized traffic on the MEM_LAT=1 instance
        free_at = 0; if_done = -1; ls_done = -1; starve = 0;
        if_st = 0; ls_st = 0; ls_exp_ld = 1'b0; if_exp = '0; ls_exp = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if_rv = (c == if_done);
            ls_rv = (c == ls_done);
            check_val("rnd_if_rvalid", 32'(bus1.if_rvalid), 32'(if_rv));
            check_val("rnd_ls_rvalid", 32'(bus1.ls_rvalid), 32'(ls_rv));
            if (if_rv) if_last = if_exp;
            check_val("rnd_if_rdata", bus1.if_rdata, if_last);
            if (ls_rv && ls_exp_ld) check_val("rnd_ls_rdata", bus1.ls_rdata, ls_exp);

            if (if_rv) if_st = 0;
            if (if_st == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus1.if_req = 1'b1; bus1.if_addr = AW'($urandom_range(0, 31)); if_st = 1;
                end else begin
                    bus1.if_req = 1'b0;
                end
            end else if (if_st == 2 && $urandom_range(0, 7) == 0) begin
                bus1.if_req = 1'b0;
            end

            if (ls_rv) ls_st = 0;
            if (ls_st == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus1.ls_req = 1'b1; bus1.ls_we = 1'($urandom_range(0, 1));
                    bus1.ls_addr = AW'($urandom_range(0, 31)); bus1.ls_wdata = DW'($urandom);
                    ls_st = 1;
                end else begin
                    bus1.ls_req = 1'b0;
                end
            end else if (ls_st == 2 && $urandom_range(0, 7) == 0) begin
                bus1.ls_req = 1'b0;
            end
            #1;

            exp_if_g = 1'b0;
            exp_ls_g = 1'b0;
            if (c >= free_at) begin
                if (bus1.ls_req && (!bus1.if_req || starve < SM)) exp_ls_g = 1'b1;
                else if (bus1.if_req)                              exp_if_g = 1'b1;
            end
            check_val("rnd_if_gnt",    32'(bus1.if_gnt),    32'(exp_if_g));
            check_val("rnd_ls_gnt",    32'(bus1.ls_gnt),    32'(exp_ls_g));
            check_val("rnd_mem_req",   32'(bus1.mem_req),   32'(exp_if_g | exp_ls_g));
            check_val("rnd_stall_if",  32'(bus1.stall_if),  32'(bus1.if_req & ~if_rv));
            check_val("rnd_stall_mem", 32'(bus1.stall_mem), 32'(bus1.ls_req & ~ls_rv));
            if (exp_ls_g) begin
                check_val("rnd_mem_addr_ls", 32'(bus1.mem_addr), 32'(bus1.ls_addr));
                check_val("rnd_mem_we_ls",   32'(bus1.mem_we),   32'(bus1.ls_we));
                if (bus1.ls_we) begin
                    check_val("rnd_mem_wdata", bus1.mem_wdata, bus1.ls_wdata);
                    ref_wr1(bus1.ls_addr, bus1.ls_wdata);
                end else begin
                    ls_exp = ref_rd1(bus1.ls_addr);
                end
                ls_exp_ld = !bus1.ls_we;
                ls_st = 2; ls_done = c + 2; free_at = c + 2;
            end
            if (exp_if_g) begin
                check_val("rnd_mem_addr_if", 32'(bus1.mem_addr), 32'(bus1.if_addr));
                check_val("rnd_mem_we_if",   32'(bus1.mem_we),   32'd0);
                if_exp = ref_rd1(bus1.if_addr);
                if_st = 2; if_done = c + 2; free_at = c + 2;
            end
            if (!bus1.if_req || exp_if_g) starve = 0;
            else if (exp_ls_g && starve < SM) starve++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
